// File: rtl/arb_requester.sv
// Requester-side agent for the 8-way rotating-priority arbiter: queues burst
// commands, requests one granted beat per cycle, and flags starvation/protocol faults.
module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             req,
    input  logic             gnt,
    output logic             beat,
    output logic             done,
    output logic             busy,
    output logic             starve,
    output logic             proto_err
);
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ZERO  = '0;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             empty, full, push, pop;
    logic [LEN_W-1:0] head_len;

    logic [LEN_W-1:0]  beats_left;
    logic              req_q;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              active, last_beat;

    // Command FIFO: the extra pointer bit tells full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push     = cmd_valid && !full;
    assign pop      = (state == IDLE) && !empty;
    assign head_len = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= cmd_len;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A zero-length command is popped and dropped without leaving IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop && head_len != LEN_ZERO) state_nxt = ACTIVE;
            ACTIVE:  if (last_beat)                   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req drops combinationally on the last granted beat so no stray grant follows.
    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        active    = (state == ACTIVE);
        beat      = active && gnt && req_q;
        last_beat = beat && (beats_left == LEN_ONE);
        req       = active && !last_beat;
        done      = last_beat;
        busy      = active || !empty;
        cmd_ready = !full;
    end

    always_comb begin
        wait_nxt = wait_cnt;
        if (!active || beat)
            wait_nxt = '0;
        else if (req_q && wait_cnt != WAIT_MAX)
            wait_nxt = wait_cnt + WAIT_ONE;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_left <= '0;
            req_q      <= 1'b0;
            wait_cnt   <= '0;
            starve     <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            req_q    <= req;
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_TRIP) starve    <= 1'b1;
            if (gnt && !req_q)         proto_err <= 1'b1;
            if (pop)
                beats_left <= head_len;
            else if (beat)
                beats_left <= beats_left - LEN_ONE;
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios plus random traffic,
// every cycle compared against a queue-based transaction model.
module tb_arb_requester;
    localparam int LEN_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             req;
    logic             gnt;
    logic             beat;
    logic             done;
    logic             busy;
    logic             starve;
    logic             proto_err;

    always #5 clk = ~clk;

    arb_requester #(
        .LEN_W  (LEN_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len  (cmd_len),
        .req      (req),
        .gnt      (gnt),
        .beat     (beat),
        .done     (done),
        .busy     (busy),
        .starve   (starve),
        .proto_err(proto_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: pending lengths, beats remaining in the current burst,
    // last cycle's request, and the run of unanswered request cycles.
    int m_fifo[$];
    int m_rem;
    bit m_req_q;
    int m_wait;
    bit m_starve;
    bit m_proto;

    // Observations from the DUT for scenario-level totals.
    int beat_seen;
    int done_seen;
    int req_seen;
    int run_beats;
    int done_lens[$];

    bit pat [7]      = '{1, 0, 0, 1, 1, 0, 1};
    int fifo_lens [5] = '{2, 1, 5, 3, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_rem    = 0;
        m_req_q  = 1'b0;
        m_wait   = 0;
        m_starve = 1'b0;
        m_proto  = 1'b0;
    endtask

    task automatic clear_counts();
        beat_seen = 0;
        done_seen = 0;
        req_seen  = 0;
        run_beats = 0;
        done_lens.delete();
    endtask

    // Compare this cycle's outputs with the model, then advance the model past the edge.
    task automatic eval_cycle();
        bit in_burst, e_ready, e_beat, e_done, e_req, e_busy, accept;
        in_burst = (m_rem > 0);
        e_ready  = (m_fifo.size() < DEPTH);
        e_beat   = in_burst && gnt && m_req_q;
        e_done   = e_beat && (m_rem == 1);
        e_req    = in_burst && !e_done;
        e_busy   = in_burst || (m_fifo.size() != 0);

        check("cmd_ready", cmd_ready, e_ready);
        check("req",       req,       e_req);
        check("beat",      beat,      e_beat);
        check("done",      done,      e_done);
        check("busy",      busy,      e_busy);
        check("starve",    starve,    m_starve);
        check("proto_err", proto_err, m_proto);

        if (beat === 1'b1) begin
            beat_seen++;
            run_beats++;
        end
        if (req === 1'b1) req_seen++;
        if (done === 1'b1) begin
            done_seen++;
            done_lens.push_back(run_beats);
            run_beats = 0;
        end

        if (rst) begin
            model_reset();
            run_beats = 0;
            return;
        end

        accept = cmd_valid && e_ready;
        if (!in_burst || e_beat) m_wait = 0;
        else if (m_req_q)        m_wait++;
        if (m_wait >= TIMEOUT - 1) m_starve = 1'b1;
        if (gnt && !m_req_q)       m_proto  = 1'b1;
        if (in_burst) begin
            if (e_beat) m_rem--;
        end else if (m_fifo.size() != 0) begin
            m_rem = m_fifo.pop_front();
        end
        if (accept) m_fifo.push_back(int'(cmd_len));
        m_req_q = e_req;
    endtask

    // Called just after a posedge: drive, check at the negedge, return after the next posedge.
    task automatic tick(input bit v, input logic [LEN_W-1:0] len, input bit g, input bit r);
        cmd_valid = v;
        cmd_len   = len;
        gnt       = g;
        rst       = r;
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    // Arbiter that always grants: gnt follows last cycle's request.
    task automatic run_echo(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, m_req_q, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        gnt       = 1'b0;
        model_reset();
        clear_counts();
        @(posedge clk);
        #1;
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);

        // Single uncontested burst of 3.
        clear_counts();
        tick(1'b1, 4'd3, m_req_q, 1'b0);
        run_echo(8);
        check("s1_beats", beat_seen, 3);
        check("s1_req_cycles", req_seen, 3);
        check("s1_done", done_seen, 1);
        check("s1_proto", proto_err, 0);

        // Contended grants on a burst of 4.
        clear_counts();
        tick(1'b1, 4'd4, m_req_q, 1'b0);
        for (int i = 0; i < 10 && !m_req_q; i++) tick(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, '0, pat[i] & m_req_q, 1'b0);
        run_echo(3);
        check("s2_beats", beat_seen, 4);
        check("s2_req_cycles", req_seen, 7);
        check("s2_done", done_seen, 1);

        // Fill the FIFO with grants withheld, then drain in order.
        clear_counts();
        begin
            int idx = 0;
            for (int i = 0; i < 40 && idx < 5; i++) begin
                bit acc = (m_fifo.size() < DEPTH);
                tick(1'b1, LEN_W'(fifo_lens[idx]), 1'b0, 1'b0);
                if (acc) idx++;
            end
        end
        tick(1'b0, '0, 1'b0, 1'b0);
        check("s3_ready_full", cmd_ready, 0);
        for (int i = 0; i < 200 && (m_rem != 0 || m_fifo.size() != 0); i++)
            tick(1'b0, '0, m_req_q, 1'b0);
        run_echo(2);
        check("s3_dones", done_lens.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < done_lens.size()) check("s3_len", done_lens[i], fifo_lens[i]);
        check("s3_beats", beat_seen, 18);

        // Zero-length command followed by a 2-beat burst.
        clear_counts();
        tick(1'b1, 4'd0, m_req_q, 1'b0);
        tick(1'b1, 4'd2, m_req_q, 1'b0);
        run_echo(8);
        check("s4_done", done_seen, 1);
        check("s4_beats", beat_seen, 2);
        check("s4_req_cycles", req_seen, 2);

        // Starvation, then a grant while idle.
        clear_counts();
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, '0, 1'b0, 1'b0);
        check("s5_starve", starve, 1);
        run_echo(4);
        check("s5_done", done_seen, 1);
        clear_counts();
        tick(1'b0, '0, 1'b1, 1'b0);
        check("s5_proto", proto_err, 1);
        check("s5_proto_beat", beat_seen, 0);
        tick(1'b0, '0, 1'b0, 1'b0);

        // Reset in the middle of a 6-beat burst.
        clear_counts();
        tick(1'b1, 4'd6, m_req_q, 1'b0);
        for (int i = 0; i < 20 && beat_seen < 2; i++) tick(1'b0, '0, m_req_q, 1'b0);
        tick(1'b0, '0, m_req_q, 1'b1);
        check("s6_req", req, 0);
        check("s6_busy", busy, 0);
        check("s6_starve", starve, 0);
        check("s6_proto", proto_err, 0);
        check("s6_no_done", done_seen, 0);
        clear_counts();
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        run_echo(6);
        check("s6_after_done", done_seen, 1);

        // Random traffic: mostly well-behaved grants, occasional stray grants and resets.
        for (int i = 0; i < 3000; i++) begin
            bit               v, g, r;
            logic [LEN_W-1:0] l;
            int               p;
            v = ($urandom_range(0, 2) == 0);
            l = LEN_W'($urandom_range(0, 6));
            p = $urandom_range(0, 99);
            if (p < 2)       g = 1'b1;
            else if (p < 70) g = m_req_q;
            else             g = 1'b0;
            r = ($urandom_range(0, 299) == 0);
            tick(v, l, g, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for the 8-way rotating-priority arbiter; one instance drives one req bit and watches the matching gnt bit.
- Accepts burst commands (beat count) from a local master, queues them, asserts req, and consumes exactly one beat per granted cycle.
- Because the arbiter re-arbitrates every cycle, grants are per-cycle and not held; the block never over-requests.
- Also flags starvation and protocol errors (grant without a prior request).

Parameters:
LEN_W, 4, width of the burst-length field; max burst is 2^LEN_W-1 beats.
DEPTH, 4, command FIFO depth; power of 2, >=2.
TIMEOUT, 64, consecutive req-high/no-gnt cycles before starve is set; >=2.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_len  in  LEN_W  burst length in beats
req  out  1  request to arbiter (one bit of its req vector)
gnt  in  1  matching bit of arbiter gnt (registered in arbiter)
beat  out  1  a beat is granted this cycle
done  out  1  single-cycle pulse on the last beat of a burst
busy  out  1  burst active or FIFO non-empty
starve  out  1  sticky starvation flag
proto_err  out  1  sticky flag: gnt seen while req was low the previous cycle

Behaviour:
- Reset (rst=1 at posedge): FIFO empty; active=0; beats_left=0; req_q=0; wait_cnt=0; starve=0; proto_err=0.
  - After reset, outputs are: req=0, beat=0, done=0, busy=0, cmd_ready=1.
- rst mid-burst aborts the burst and flushes the FIFO; no done pulse is produced.
- Command FIFO:
  - Write when cmd_valid & cmd_ready; cmd_ready = !full.
  - cmd_len=0 is written and, on pop, discarded in one cycle with no req and no done.
- Control states:
  - IDLE (active=0): if the FIFO is non-empty, pop at the posedge.
    - A nonzero length loads beats_left and goes to ACTIVE.
    - A zero length stays in IDLE.
  - ACTIVE (active=1):
    - req = !(beats_left==1 & gnt & req_q), combinational.
    - req_q is req registered; it is required because arbiter gnt reflects the previous cycle's req.
    - beat = gnt & req_q & active. Each beat decrements beats_left.
    - When beats_left==1 and a beat occurs: done=1 the same cycle, active clears at the edge, and req drops the same cycle so no stray grant follows.
    - From ACTIVE with a non-empty FIFO, the next command is not popped until active has cleared (IDLE for at least one cycle).
- Latency:
  - Handshake accepted at posedge E0 → pop at E1 → req=1 in the cycle after E1.
  - First possible beat is one cycle later.
  - A burst of N beats with uncontested grants has req high N cycles and beat high N cycles, offset by 1.
- req is 0 whenever active=0.
- Starvation:
  - wait_cnt increments each cycle with req_q=1 and no beat; it clears on a beat or when active=0.
  - When wait_cnt reaches TIMEOUT-1, starve is set; it is sticky until rst.
  - The burst continues regardless.
- Protocol error: gnt=1 while req_q=0 sets proto_err (sticky). That grant is ignored and counts no beat.
- busy = active | !empty.
- Widths: beats_left is LEN_W bits; wait_cnt is clog2(TIMEOUT)+1 bits and saturates.

Test Plan:
- Single burst: cmd_len=3 with gnt echoing req_q every cycle → req high 3 cycles, beat on 3 consecutive cycles, done on the 3rd beat, req low that same cycle, no proto_err.
- Contended grants: cmd_len=4, gnt pattern 1,0,0,1,1,0,1 aligned to req_q → exactly 4 beats, req stays high through gaps and drops on the last-beat cycle, done once.
- FIFO full / back-to-back: push lengths 2,1,5,3,7 with gnt held at 0 → cmd_ready=0 after 4 accepted plus 1 popped (5th accepted only after pop). Then enable grants → done pulses in order for lengths 2,1,5,3,7; busy falls one cycle after the final done.
- Zero length: push lengths 0 then 2 → the 0 produces no req and no done; the 2-beat burst completes normally.
- Starvation / protocol: cmd_len=1 with TIMEOUT=8 and gnt=0 → starve=1 after 8 req cycles. Separately, force gnt=1 while idle → proto_err=1 with beat=0.
- Reset mid-burst: cmd_len=6, assert rst after 2 beats → next cycle req=0, busy=0, flags=0, no done; a later cmd_len=1 completes normally.
